// File: rtl/frontend_loader.sv
// Frontend loader: packs a WORD_W-bit word stream MSB-first into one BLOCK_W-bit block
// and hands it to the frontend over a valid/ready handshake. A block closes when it is
// full or when in_last is accepted; unused slots of a short block read as zero.
// Optional build macro FRONTEND_LOADER_BSWAP_EN byte-reverses each word before packing.
module frontend_loader #(
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned BLOCK_W = 4096,
    localparam int unsigned WORDS  = BLOCK_W / WORD_W,
    localparam int unsigned CNT_W  = $clog2(WORDS) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WORD_W-1:0]  in_data,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    output logic [BLOCK_W-1:0] blk_data,
    output logic               blk_valid,
    input  logic               blk_ready,
    output logic [CNT_W-1:0]   blk_words,
    output logic               blk_last
);

    localparam int unsigned SHW = $clog2(BLOCK_W);

    typedef enum logic [0:0] {StFill, StHold} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   words_q, words_d;
    logic [BLOCK_W-1:0] data_q, data_d;
    logic               last_q, last_d;

    logic [WORD_W-1:0]  word;
    logic [CNT_W-1:0]   slot_idx;
    logic [SHW-1:0]     shamt;
    logic               accept;
    logic               closing;

`ifdef FRONTEND_LOADER_BSWAP_EN
    // Byte-reverse the incoming word: in_data[7:0] becomes the top byte of the slot
    always_comb begin
        word = '0;
        for (int unsigned b = 0; b < WORD_W / 8; b++) begin
            word[WORD_W-1-8*b -: 8] = in_data[8*b +: 8];
        end
    end
`else
    // Words are packed unchanged
    always_comb begin
        word = in_data;
    end
`endif

    // Slot k sits k words below the MSB, i.e. (WORDS-1-k) words above bit 0
    assign slot_idx = CNT_W'(WORDS - 1) - cnt_q;
    assign shamt    = SHW'(slot_idx) * SHW'(WORD_W);
    assign accept   = (state_q == StFill) && in_valid;
    assign closing  = accept && (in_last || (cnt_q == CNT_W'(WORDS - 1)));

    // Next-state logic: fill slots, close on full/last, clear everything on hand-off
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        words_d = words_q;
        data_d  = data_q;
        last_d  = last_q;
        unique case (state_q)
            StFill: begin
                if (accept) begin
                    // Target slot is still zero (cleared on hand-off), so OR is a write
                    data_d = data_q | (BLOCK_W'(word) << shamt);
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (closing) begin
                        state_d = StHold;
                        words_d = cnt_q + CNT_W'(1);
                        last_d  = in_last;
                    end
                end
            end
            StHold: begin
                if (blk_ready) begin
                    state_d = StFill;
                    cnt_d   = '0;
                    words_d = '0;
                    data_d  = '0;
                    last_d  = 1'b0;
                end
            end
            default: state_d = StFill;
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StFill;
            cnt_q   <= '0;
            words_q <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            words_q <= words_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign in_ready  = (state_q == StFill);
    assign blk_valid = (state_q == StHold);
    assign blk_data  = data_q;
    assign blk_words = words_q;
    assign blk_last  = last_q;

endmodule
